// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator
//   Accumulates LEN consecutive signed 8-bit products from the Booth
//   multiplier into a signed ACC_W-bit sum. The finished sum is presented on
//   a held valid/ready handshake. Once the handshake completes, the block
//   clears itself for the next set of products.
//
//   Optional build macro: ACC_SATURATE_EN
//     defined   - a signed overflow clamps the accumulator to the most
//                 positive or most negative ACC_W-bit value
//     undefined - a signed overflow wraps in two's complement
//   The overflow flag is raised in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   clear      in   synchronous abort/clear; highest priority after reset
//   in_valid   in   product is valid this cycle
//   in_ready   out  block accepts a product this cycle (low in DONE)
//   product    in   signed 8-bit product
//   out_valid  out  out_sum holds a completed block result
//   out_ready  in   downstream accepts out_sum
//   out_sum    out  signed accumulated sum (running value while not valid)
//   overflow   out  sticky signed-overflow flag for the current block
//   count      out  products accepted in the current block
module booth_product_accumulator #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             overflow,
  output logic [7:0]       count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  state_t           state_reg, state_next;
  logic             live_reg;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [7:0]       count_reg, count_next;
  logic             ovf_reg, ovf_next;

  logic [ACC_W-1:0] product_ext;
  logic [ACC_W-1:0] sum_raw;
  logic [ACC_W-1:0] sum_fixed;
  logic             add_ovf;
  logic             accept;
  logic             consume;

  // Signed overflow happens only when both operands have the same sign and
  // the result at ACC_W bits has the opposite sign.
  assign product_ext = {{(ACC_W-8){product[7]}}, product};
  assign sum_raw     = acc_reg + product_ext;
  assign add_ovf     = (acc_reg[ACC_W-1] == product[7]) &&
                       (sum_raw[ACC_W-1] != acc_reg[ACC_W-1]);

`ifdef ACC_SATURATE_EN
  // On overflow, clamp toward the sign the two operands shared.
  always_comb begin
    sum_fixed = sum_raw;
    if (add_ovf) begin
      sum_fixed = acc_reg[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign sum_fixed = sum_raw;
`endif

  // Clear overrides both the input and the output handshake.
  assign accept  = in_valid && in_ready && !clear;
  assign consume = out_valid && out_ready && !clear;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            state_next = (count_reg == LAST_IDX) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Outputs. in_ready stays low while reset is held. It also stays low
  // until the first clock edge after reset is released, which live_reg tracks.
  always_comb begin
    in_ready  = live_reg && (state_reg != DONE);
    out_valid = (state_reg == DONE);
    out_sum   = acc_reg;
    overflow  = ovf_reg;
    count     = count_reg;
  end

  // Datapath next values.
  always_comb begin
    acc_next   = acc_reg;
    count_next = count_reg;
    ovf_next   = ovf_reg;
    if (clear || consume) begin
      acc_next   = '0;
      count_next = '0;
      ovf_next   = 1'b0;
    end else if (accept) begin
      acc_next   = sum_fixed;
      count_next = count_reg + 8'd1;
      ovf_next   = ovf_reg || add_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_reg  <= 1'b0;
      acc_reg   <= '0;
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      live_reg  <= 1'b1;
      acc_reg   <= acc_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: LEN=4, ACC_W=12.
  logic        clear_a = 1'b0, in_valid_a = 1'b0, out_ready_a = 1'b1;
  logic [7:0]  product_a = 8'h00;
  logic        in_ready_a, out_valid_a, overflow_a;
  logic [11:0] out_sum_a;
  logic [7:0]  count_a;

  // Instance B: LEN=4, ACC_W=9 (overflow cases).
  logic        clear_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic [7:0]  product_b = 8'h00;
  logic        in_ready_b, out_valid_b, overflow_b;
  logic [8:0]  out_sum_b;
  logic [7:0]  count_b;

  // Instance C: LEN=1, ACC_W=12.
  logic        clear_c = 1'b0, in_valid_c = 1'b0, out_ready_c = 1'b1;
  logic [7:0]  product_c = 8'h00;
  logic        in_ready_c, out_valid_c, overflow_c;
  logic [11:0] out_sum_c;
  logic [7:0]  count_c;

  booth_product_accumulator #(.LEN(4), .ACC_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .product(product_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_sum(out_sum_a), .overflow(overflow_a),
    .count(count_a));

  booth_product_accumulator #(.LEN(4), .ACC_W(9)) dut_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .product(product_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_sum(out_sum_b), .overflow(overflow_b),
    .count(count_b));

  booth_product_accumulator #(.LEN(1), .ACC_W(12)) dut_c (
    .clk(clk), .rst_n(rst_n), .clear(clear_c), .in_valid(in_valid_c),
    .in_ready(in_ready_c), .product(product_c), .out_valid(out_valid_c),
    .out_ready(out_ready_c), .out_sum(out_sum_c), .overflow(overflow_c),
    .count(count_c));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0]  p [4];
    logic [11:0] sum;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0].p = '{8'h0C, 8'hFA, 8'h40, 8'hC8}; vecs[0].sum = 12'h00E; // 12-6+64-56
    vecs[1].p = '{8'h7F, 8'h7F, 8'h7F, 8'h7F}; vecs[1].sum = 12'h1FC; // 508
    vecs[2].p = '{8'h80, 8'h80, 8'h80, 8'h80}; vecs[2].sum = 12'hE00; // -512
    vecs[3].p = '{8'h01, 8'hFF, 8'h02, 8'hFE}; vecs[3].sum = 12'h000;
    vecs[4].p = '{8'h7F, 8'h7F, 8'h80, 8'h01}; vecs[4].sum = 12'h07F; // 127

    // Reset values while rst_n is low.
    #2;
    check("rst_in_ready", 32'(in_ready_a), 32'h0);
    check("rst_out_valid", 32'(out_valid_a), 32'h0);
    check("rst_out_sum", 32'(out_sum_a), 32'h0);
    check("rst_overflow", 32'(overflow_a), 32'h0);
    check("rst_count", 32'(count_a), 32'h0);
    step();
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready_before_edge", 32'(in_ready_a), 32'h0);
    step();
    check("rel_in_ready_after_edge", 32'(in_ready_a), 32'h1);

    // Table-driven blocks, back-to-back, out_ready=1.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("v%0d_in_ready_%0d", v, k), 32'(in_ready_a), 32'h1);
        product_a = vecs[v].p[k];
        in_valid_a = 1'b1;
        step();
      end
      in_valid_a = 1'b0;
      check($sformatf("v%0d_out_valid", v), 32'(out_valid_a), 32'h1);
      check($sformatf("v%0d_out_sum", v), 32'(out_sum_a), 32'(vecs[v].sum));
      check($sformatf("v%0d_overflow", v), 32'(overflow_a), 32'h0);
      step();
      check($sformatf("v%0d_idle_valid", v), 32'(out_valid_a), 32'h0);
      check($sformatf("v%0d_idle_count", v), 32'(count_a), 32'h0);
    end

    // Backpressure: complete a block of four 8'h01 products with out_ready=0.
    out_ready_a = 1'b0;
    product_a = 8'h01;
    in_valid_a = 1'b1;
    for (int k = 0; k < 4; k++) step();
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_in_ready_%0d", k), 32'(in_ready_a), 32'h0);
      check($sformatf("bp_out_valid_%0d", k), 32'(out_valid_a), 32'h1);
      check($sformatf("bp_out_sum_%0d", k), 32'(out_sum_a), 32'h004);
      check($sformatf("bp_count_%0d", k), 32'(count_a), 32'h4);
      step();
    end
    out_ready_a = 1'b1;
    step();
    check("bp_release_valid", 32'(out_valid_a), 32'h0);
    check("bp_release_count", 32'(count_a), 32'h0);
    step();
    check("bp_next_count", 32'(count_a), 32'h1);
    in_valid_a = 1'b0;
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    check("bp_clear_count", 32'(count_a), 32'h0);

    // Clear in the middle of a block, while a product is also presented.
    product_a = 8'h05;
    in_valid_a = 1'b1;
    step();
    step();
    check("clr_pre_count", 32'(count_a), 32'h2);
    check("clr_pre_sum", 32'(out_sum_a), 32'h00A);
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    in_valid_a = 1'b0;
    check("clr_count", 32'(count_a), 32'h0);
    check("clr_overflow", 32'(overflow_a), 32'h0);
    check("clr_sum", 32'(out_sum_a), 32'h0);
    product_a = 8'h01;
    in_valid_a = 1'b1;
    for (int k = 0; k < 4; k++) step();
    in_valid_a = 1'b0;
    check("clr_blk_valid", 32'(out_valid_a), 32'h1);
    check("clr_blk_sum", 32'(out_sum_a), 32'h004);
    step();

    // Overflow on the 9-bit accumulator: 4 x 64 = 256 is out of range.
    product_b = 8'h40;
    in_valid_b = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("ovf_pre_flag", 32'(overflow_b), 32'h0);
    check("ovf_pre_sum", 32'(out_sum_b), 32'h0C0);
    step();
    in_valid_b = 1'b0;
    check("ovf_valid", 32'(out_valid_b), 32'h1);
    check("ovf_flag", 32'(overflow_b), 32'h1);
`ifdef ACC_SATURATE_EN
    check("ovf_sum", 32'(out_sum_b), 32'h0FF);
`else
    check("ovf_sum", 32'(out_sum_b), 32'h100);
`endif
    step();
    check("ovf_cleared", 32'(overflow_b), 32'h0);

    // LEN=1 with gapped input: each accept completes a block.
    for (int k = 0; k < 3; k++) begin
      product_c = 8'hF8;
      in_valid_c = 1'b1;
      step();
      in_valid_c = 1'b0;
      check($sformatf("len1_valid_%0d", k), 32'(out_valid_c), 32'h1);
      check($sformatf("len1_sum_%0d", k), 32'(out_sum_c), 32'hFF8);
      step();
      check($sformatf("len1_drop_%0d", k), 32'(out_valid_c), 32'h0);
      step();
    end

    // Asynchronous reset while a result is held in DONE.
    out_ready_a = 1'b0;
    product_a = 8'h03;
    in_valid_a = 1'b1;
    for (int k = 0; k < 4; k++) step();
    in_valid_a = 1'b0;
    check("ar_held_valid", 32'(out_valid_a), 32'h1);
    check("ar_held_sum", 32'(out_sum_a), 32'h00C);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid_a), 32'h0);
    check("ar_sum", 32'(out_sum_a), 32'h0);
    check("ar_count", 32'(count_a), 32'h0);
    check("ar_in_ready", 32'(in_ready_a), 32'h0);
    #1 rst_n = 1'b1;
    #1 check("ar_in_ready_before_edge", 32'(in_ready_a), 32'h0);
    step();
    check("ar_in_ready_after_edge", 32'(in_ready_a), 32'h1);
    out_ready_a = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
